alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 8-bit combinational ALU in the CPU datapath.
- Supports any data width and registers every result. Completes the shift op iteratively, one bit position per cycle.
- Sits between the register-file read stage and writeback. Valid/ready handshakes on both sides let the control FSM stall on multi-cycle ops.

---
 rtl/alu_pipe_pkg.sv | 22 ++
 rtl/alu_pipe_core.sv | 41 ++++
 rtl/alu_pipe.sv | 96 +++++++++
 tb/tb_alu_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode mnemonics and FSM state type for the pipelined ALU
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    XOR   = 3'b000,
    RXOR  = 3'b001,
    OR    = 3'b010,
    EQ    = 3'b011,
    AND   = 3'b100,
    PASS  = 3'b101,
    SHIFT = 3'b110,
    ADD   = 3'b111
  } op_mne;

  // state names carry an S_ prefix so they do not collide with the SHIFT opcode
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } alu_state_t;

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational single-cycle ALU results plus one-position shift step
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_mne            op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] work,
  input  logic             dir,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] step
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    carry  = 1'b0;
    unique case (op)
      XOR:  result = a ^ b;
      RXOR: result[0] = ^a;
      OR:   result = a | b;
      EQ:   result[0] = (a == b);
      AND:  result = a & b;
      // a shift by zero completes immediately as a pass-through
      PASS, SHIFT: result = a;
      ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      default: result = '0;
    endcase
  end

  assign step = dir ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered results and an iterative bit-serial shifter
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [SHW:0]     Shmt,
  input  logic [2:0]       OP,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Carry
);

  alu_state_t       state, state_nxt;
  op_mne            op;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             dir;
  logic [WIDTH-1:0] core_result, core_step;
  logic             core_carry;
  logic             accept, shift_start, last_step;

  assign op          = op_mne'(OP);
  assign InReady     = (state == S_IDLE) || (state == S_DONE && OutReady);
  assign accept      = InValid && InReady;
  assign shift_start = accept && (op == SHIFT) && (Shmt[SHW-1:0] != '0);
  assign last_step   = (state == S_SHIFT) && (cnt == SHW'(1));
  assign OutValid    = (state == S_DONE);

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .a      (InputA),
    .b      (InputB),
    .work   (work),
    .dir    (dir),
    .result (core_result),
    .carry  (core_carry),
    .step   (core_step)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = shift_start ? S_SHIFT : S_DONE;
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_SHIFT: if (last_step) state_nxt = S_DONE;
        S_DONE:  if (OutReady) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      Out   <= '0;
      Zero  <= 1'b1;
      Carry <= 1'b0;
      work  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (shift_start) begin
        work <= InputA;
        cnt  <= Shmt[SHW-1:0];
        dir  <= Shmt[SHW];
      end else if (accept) begin
        Out   <= core_result;
        Zero  <= (core_result == '0);
        Carry <= core_carry;
      end else if (state == S_SHIFT) begin
        work <= core_step;
        cnt  <= cnt - SHW'(1);
        // the final step lands straight in Out so OutValid rises with the DONE state
        if (last_step) begin
          Out   <= core_step;
          Zero  <= (core_step == '0);
          Carry <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8, carry8;
  logic [7:0] a8, b8, out8;
  logic [3:0] shmt8;
  logic [2:0] op8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, carry16;
  logic [15:0] a16, b16, out16;
  logic [4:0]  shmt16;
  logic [2:0]  op16;

  int n_checks = 0;
  int n_pass   = 0;

  alu_pipe #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .InValid(in_valid8), .InReady(in_ready8),
    .InputA(a8), .InputB(b8), .Shmt(shmt8), .OP(op8),
    .OutValid(out_valid8), .OutReady(out_ready8), .Out(out8), .Zero(zero8), .Carry(carry8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(rst), .InValid(in_valid16), .InReady(in_ready16),
    .InputA(a16), .InputB(b16), .Shmt(shmt16), .OP(op16),
    .OutValid(out_valid16), .OutReady(out_ready16), .Out(out16), .Zero(zero16), .Carry(carry16)
  );

  // {carry, result} from plain arithmetic on the operand values
  function automatic logic [8:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] shmt);
    int unsigned ua, ub, n;
    ua = a;
    ub = b;
    n  = shmt[2:0];
    case (op)
      3'd0:    return 9'(ua ^ ub);
      3'd1:    return 9'($countones(a) % 2);
      3'd2:    return 9'(ua | ub);
      3'd3:    return (ua == ub) ? 9'd1 : 9'd0;
      3'd4:    return 9'(ua & ub);
      3'd5:    return 9'(ua);
      3'd6:    return shmt[3] ? 9'(ua / (32'd1 << n)) : 9'((ua * (32'd1 << n)) % 256);
      default: return 9'(ua + ub);
    endcase
  endfunction

  // negedges from accept until OutValid is seen: n stall cycles plus the result cycle
  function automatic int lat8(input logic [2:0] op, input logic [3:0] shmt);
    if (op == 3'd6 && shmt[2:0] != 3'd0) return int'(shmt[2:0]) + 1;
    return 1;
  endfunction

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] shmt);
    op8 = op; a8 = a; b8 = b; shmt8 = shmt; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    int i;
    i = 0; lat = -1;
    while (lat < 0 && i < 40) begin
      @(negedge clk); i++;
      if (out_valid8 === 1'b1) lat = i;
    end
  endtask

  task automatic wait_valid16(output int lat);
    int i;
    i = 0; lat = -1;
    while (lat < 0 && i < 40) begin
      @(negedge clk); i++;
      if (out_valid16 === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; shmt8 = 0; op8 = 0;
    in_valid16 = 0; out_ready16 = 1; a16 = 0; b16 = 0; shmt16 = 0; op16 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid8); else n_pass++;
    n_checks++; if (out8 !== 8'h00) $display("FAIL reset_out: got %h expected 00", out8); else n_pass++;
    n_checks++; if (zero8 !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero8); else n_pass++;
    n_checks++; if (carry8 !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry8); else n_pass++;
    n_checks++; if (in_ready8 !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready8); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    send8(ADD, 8'hF0, 8'h20, 4'h0);
    wait_valid8(lat);
    n_checks++; if (lat != 1) $display("FAIL add_latency: got %0d expected 1", lat); else n_pass++;
    n_checks++; if (out8 !== 8'h10) $display("FAIL add_out: got %h expected 10", out8); else n_pass++;
    n_checks++; if (carry8 !== 1'b1) $display("FAIL add_carry: got %b expected 1", carry8); else n_pass++;
    n_checks++; if (zero8 !== 1'b0) $display("FAIL add_zero: got %b expected 0", zero8); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    op8 = XOR; a8 = 8'h0F; b8 = 8'hF0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    op8 = EQ; a8 = 8'hAA; b8 = 8'hAA;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b1 || out8 !== 8'hFF) $display("FAIL b2b_xor: got v=%b out=%h expected v=1 out=ff", out_valid8, out8); else n_pass++;
    n_checks++; if (in_ready8 !== 1'b1) $display("FAIL b2b_ready1: got %b expected 1", in_ready8); else n_pass++;
    @(posedge clk); #1;
    op8 = RXOR; a8 = 8'hAA; b8 = 8'($urandom);
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b1 || out8 !== 8'h01) $display("FAIL b2b_eq: got v=%b out=%h expected v=1 out=01", out_valid8, out8); else n_pass++;
    n_checks++; if (in_ready8 !== 1'b1) $display("FAIL b2b_ready2: got %b expected 1", in_ready8); else n_pass++;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b1 || out8 !== 8'h00 || zero8 !== 1'b1) $display("FAIL b2b_rxor: got v=%b out=%h z=%b expected v=1 out=00 z=1", out_valid8, out8, zero8); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid8); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_shift;
    int lat;
    send8(SHIFT, 8'hAA, 8'h00, 4'b1011);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready8 !== 1'b0 || out_valid8 !== 1'b0) $display("FAIL shift_stall%0d: got ready=%b valid=%b expected 0 0", i, in_ready8, out_valid8); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b1 || out8 !== 8'h15 || carry8 !== 1'b0) $display("FAIL shift_right3: got v=%b out=%h c=%b expected v=1 out=15 c=0", out_valid8, out8, carry8); else n_pass++;
    @(posedge clk); #1;
    send8(SHIFT, 8'hAA, 8'h00, 4'b0001);
    wait_valid8(lat);
    n_checks++; if (lat != 2 || out8 !== 8'h54) $display("FAIL shift_left1: got lat=%0d out=%h expected lat=2 out=54", lat, out8); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [7:0] a, b, exp;
    a = 8'($urandom) | 8'h81; b = 8'($urandom) | 8'h01;
    exp = ref8(3'd4, a, b, 4'h0);
    out_ready8 = 1'b0;
    send8(AND, a, b, 4'($urandom));
    wait_valid8(lat);
    n_checks++; if (lat != 1 || out8 !== exp) $display("FAIL bp_first: got lat=%0d out=%h expected lat=1 out=%h", lat, out8, exp); else n_pass++;
    @(posedge clk); #1;
    op8 = PASS; a8 = ~a; in_valid8 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++; if (out_valid8 !== 1'b1 || out8 !== exp || zero8 !== (exp == 8'h00) || carry8 !== 1'b0 || in_ready8 !== 1'b0)
        $display("FAIL bp_hold: got v=%b out=%h z=%b c=%b rdy=%b expected v=1 out=%h z=%b c=0 rdy=0", out_valid8, out8, zero8, carry8, in_ready8, exp, exp == 8'h00);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready8 = 1'b1; in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b1) $display("FAIL bp_release: got rdy=%b v=%b expected 1 1", in_ready8, out_valid8); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) $display("FAIL bp_done: got %b expected 0", out_valid8); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [3:0] shmt;
    logic [8:0] exp;
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      shmt = 4'($urandom_range(0, 15));
      if (t % 8 == 3) b = a;
      exp = ref8(op, a, b, shmt);
      send8(op, a, b, shmt);
      wait_valid8(lat);
      n_checks++;
      if (lat != lat8(op, shmt) || out8 !== exp[7:0] || carry8 !== exp[8] || zero8 !== (exp[7:0] == 8'h00))
        $display("FAIL rand%0d op=%0d a=%h b=%h shmt=%h: got lat=%0d out=%h c=%b z=%b expected lat=%0d out=%h c=%b z=%b",
                 t, op, a, b, shmt, lat, out8, carry8, zero8, lat8(op, shmt), exp[7:0], exp[8], exp[7:0] == 8'h00);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_shift;
    int lat;
    bit seen;
    logic [7:0] a;
    send8(PASS, 8'h5A, 8'h00, 4'h0);
    wait_valid8(lat);
    @(posedge clk); #1;
    send8(SHIFT, 8'($urandom) | 8'h01, 8'h00, 4'b0111);
    @(posedge clk); #1;
    rst = 1'b1;
    op8 = PASS; a8 = 8'hC3; in_valid8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0 || out8 !== 8'h00 || zero8 !== 1'b1 || carry8 !== 1'b0)
      $display("FAIL midshift_reset: got v=%b out=%h z=%b c=%b expected 0 00 1 0", out_valid8, out8, zero8, carry8);
    else n_pass++;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid8 === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midshift_aborted: got result=%b expected 0", seen); else n_pass++;
    @(posedge clk); #1;
    a = 8'($urandom);
    send8(PASS, a, 8'($urandom), 4'($urandom));
    wait_valid8(lat);
    n_checks++; if (lat != 1 || out8 !== a) $display("FAIL midshift_next: got lat=%0d out=%h expected lat=1 out=%h", lat, out8, a); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_width16;
    int lat;
    int unsigned sum, shl;
    shl = (32'h8001 * (32'd1 << 15)) % 65536;
    op16 = SHIFT; a16 = 16'h8001; b16 = 16'h0000; shmt16 = 5'b01111; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    wait_valid16(lat);
    n_checks++; if (lat != 16 || out16 !== 16'(shl) || zero16 !== 1'b0 || carry16 !== 1'b0)
      $display("FAIL w16_shift: got lat=%0d out=%h z=%b c=%b expected lat=16 out=%h z=0 c=0", lat, out16, zero16, carry16, 16'(shl));
    else n_pass++;
    @(posedge clk); #1;
    sum = 32'hFFFF + 32'h0001;
    op16 = ADD; a16 = 16'hFFFF; b16 = 16'h0001; shmt16 = 5'($urandom); in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    wait_valid16(lat);
    n_checks++; if (lat != 1 || out16 !== 16'(sum % 65536) || zero16 !== 1'b1 || carry16 !== 1'(sum / 65536))
      $display("FAIL w16_add: got lat=%0d out=%h z=%b c=%b expected lat=1 out=0000 z=1 c=1", lat, out16, zero16, carry16);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_backpressure();
    test_random();
    test_reset_mid_shift();
    test_width16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
